// File: rtl/mdio_pkg.sv
// Shared encodings for the Clause-22 MDIO master: FSM states, frame constants,
// register offsets and register bit positions.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4
  } state_t;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RDATA  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CMD_OP      = 10;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_TAERR  = 2;
  localparam int CTRL_IRQ_EN = 31;

  localparam int PRE_LEN  = 32;
  localparam int HDR_LEN  = 14;
  localparam int TA_LEN   = 2;
  localparam int DATA_LEN = 16;

  // Index of the final bit of each frame phase.
  function automatic logic [4:0] last_bit(input state_t s);
    case (s)
      S_PRE:   return 5'(PRE_LEN - 1);
      S_HDR:   return 5'(HDR_LEN - 1);
      S_TA:    return 5'(TA_LEN - 1);
      S_DATA:  return 5'(DATA_LEN - 1);
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: toggles mdc every div+1 clocks while run is high and flags
// the clock cycle on which each rising or falling MDC edge is taken.
module mdio_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             mdc,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic [DIV_W-1:0] cnt;
  logic             tick;

  assign tick       = run && (cnt == div);
  assign rise_pulse = tick && !mdc;
  assign fall_pulse = tick && mdc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// Avalon-MM Clause-22 MDIO master: register file, frame sequencer, bit counter
// and 16-bit data shift register. One CMD write runs a complete 64-bit frame.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int DIV_DEFAULT = 24,
  parameter int DIV_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        mdc,
  inout  wire         mdio
);

  state_t           state, state_d;
  logic [4:0]       bit_cnt, bit_cnt_d;
  logic [31:0]      cmd_q;
  logic [15:0]      shreg;
  logic [15:0]      rdata_q;
  logic [DIV_W-1:0] div_q;
  logic             irq_en, done, ta_err;
  logic             busy, op_rd, wr, cmd_wr, status_wr, frame_end, ta_set;
  logic             mdc_rise, mdc_fall, mdio_out, mdio_oe;
  logic [13:0]      hdr;
  logic [3:0]       hdr_idx;
  logic [31:0]      rd_mux;

  assign wr        = chipselect && !write_n;
  assign busy      = (state != S_IDLE);
  assign cmd_wr    = wr && (address == ADDR_CMD) && !busy;
  assign status_wr = wr && (address == ADDR_STATUS);
  assign op_rd     = cmd_q[CMD_OP];
  assign irq       = done && irq_en;
  assign hdr       = {ST, (op_rd ? OP_RD : OP_WR), cmd_q[9:5], cmd_q[4:0]};
  assign hdr_idx   = 4'd13 - bit_cnt[3:0];
  // TA bit 2 of a read must be pulled low by the PHY; a high level means nobody answered.
  assign ta_set    = (state == S_TA) && (bit_cnt == 5'd1) && op_rd && mdc_rise && (mdio == 1'b1);
  assign mdio      = mdio_oe ? mdio_out : 1'bz;

  mdio_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .div        (div_q),
    .run        (busy),
    .mdc        (mdc),
    .rise_pulse (mdc_rise),
    .fall_pulse (mdc_fall)
  );

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_wr) begin
          state_d   = S_PRE;
          bit_cnt_d = '0;
        end
      end
      default: begin
        if (mdc_fall) begin
          if (bit_cnt == last_bit(state)) begin
            bit_cnt_d = '0;
            case (state)
              S_PRE:   state_d = S_HDR;
              S_HDR:   state_d = S_TA;
              S_TA:    state_d = S_DATA;
              default: begin
                state_d   = S_IDLE;
                frame_end = 1'b1;
              end
            endcase
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    mdio_out = 1'b1;
    mdio_oe  = 1'b0;
    case (state)
      S_PRE:  mdio_oe = 1'b1;
      S_HDR: begin
        mdio_oe  = 1'b1;
        mdio_out = hdr[hdr_idx];
      end
      S_TA: begin
        mdio_oe  = !op_rd;
        mdio_out = ~bit_cnt[0];
      end
      S_DATA: begin
        mdio_oe  = !op_rd;
        mdio_out = shreg[15];
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CMD:    rd_mux = cmd_q;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]  = busy;
        rd_mux[STAT_DONE]  = done;
        rd_mux[STAT_TAERR] = ta_err;
      end
      ADDR_RDATA:  rd_mux[15:0] = rdata_q;
      default: begin
        rd_mux[CTRL_IRQ_EN] = irq_en;
        rd_mux[DIV_W-1:0]   = div_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      shreg    <= '0;
      rdata_q  <= '0;
      div_q    <= DIV_W'(DIV_DEFAULT);
      irq_en   <= 1'b0;
      done     <= 1'b0;
      ta_err   <= 1'b0;
      readdata <= '0;
    end else begin
      if (cmd_wr) begin
        cmd_q <= writedata & 32'hFFFF_07FF;
        shreg <= writedata[31:16];
      end else if ((state == S_DATA) && op_rd && mdc_rise) begin
        shreg <= {shreg[14:0], mdio};
      end else if ((state == S_DATA) && !op_rd && mdc_fall) begin
        shreg <= {shreg[14:0], 1'b0};
      end
      if (wr && (address == ADDR_CTRL)) begin
        irq_en <= writedata[CTRL_IRQ_EN];
        if (!busy) div_q <= writedata[DIV_W-1:0];
      end
      if (frame_end && op_rd) rdata_q <= shreg;
      // A set arriving with a W1C in the same cycle wins.
      done     <= frame_end || (done && !(status_wr && writedata[STAT_DONE]));
      ta_err   <= ta_set || (ta_err && !(status_wr && writedata[STAT_TAERR]));
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Scoreboard bench for mdio_master_ctrl: expected frame bits and read data are
// queued when a command is issued and consumed as MDC edges and frames complete.
module tb_mdio_master_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        mdc;
  wire         mdio;
  logic        phy_oe = 1'b0;
  logic        phy_bit = 1'b1;

  int checks = 0;
  int errors = 0;
  bit          exp_bits[$];
  logic [15:0] exp_rdata[$];
  logic [31:0] d;

  assign mdio = phy_oe ? phy_bit : 1'bz;
  pullup pu (mdio);

  always #5 clk = ~clk;

  mdio_master_ctrl #(.DIV_DEFAULT(24), .DIV_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .mdc        (mdc),
    .mdio       (mdio)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = v;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a;
    @(negedge clk);
    v = readdata;
    address = 2'd1;
  endtask

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
  endtask

  // Issues cmd and follows the frame edge by edge. lock_rise / w1c_cyc / abort_rise
  // inject a mid-frame bus write pair, a same-cycle W1C, or a reset (0 = none).
  task automatic run_frame(input logic [31:0] cmd, input int div, input bit present,
                           input logic [15:0] pdata, input int lock_rise,
                           input int w1c_cyc, input int abort_rise);
    bit          is_rd, finished, prev_mdc;
    int          cyc, rise_n, fall_n, nxt, inj, limit;
    logic [1:0]  addr_q;
    logic [15:0] dexp;
    is_rd = cmd[10];
    dexp  = present ? pdata : 16'hFFFF;
    push_bits(16'hFFFF, 16);
    push_bits(16'hFFFF, 16);
    push_bits(16'h0001, 2);
    push_bits(is_rd ? 16'h0002 : 16'h0001, 2);
    push_bits({11'b0, cmd[9:5]}, 5);
    push_bits({11'b0, cmd[4:0]}, 5);
    if (is_rd) begin
      push_bits({14'b0, 1'b1, !present}, 2);
      push_bits(dexp, 16);
      if (abort_rise == 0) exp_rdata.push_back(dexp);
    end else begin
      push_bits(16'h0002, 2);
      push_bits(cmd[31:16], 16);
    end
    bus_write(2'd0, cmd);
    limit = 128 * (div + 1) + 10;
    addr_q = address; prev_mdc = mdc;
    cyc = 0; rise_n = 0; fall_n = 0; inj = 0; finished = 1'b0;
    while (!finished && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (addr_q == 2'd1) begin
        if (cyc == 1) check("busy_start", readdata[0], 1);
        else if (!readdata[0]) finished = 1'b1;
      end
      if (mdc && !prev_mdc) begin
        rise_n++;
        if (exp_bits.size() > 0) check($sformatf("bit%0d", rise_n), mdio, exp_bits.pop_front());
        if (is_rd && rise_n >= 47) check("rd_release", dut.mdio_oe, 0);
      end
      if (!mdc && prev_mdc) begin
        fall_n++;
        nxt = fall_n + 1;
        if (present && is_rd && nxt >= 48 && nxt <= 64) begin
          phy_oe = 1'b1;
          phy_bit = (nxt == 48) ? 1'b0 : pdata[64 - nxt];
        end else begin
          phy_oe = 1'b0;
        end
      end
      prev_mdc = mdc;
      if (abort_rise != 0 && rise_n == abort_rise) begin
        reset_n = 1'b0;
        #1;
        check("rst_mdc", mdc, 0);
        check("rst_oe", dut.mdio_oe, 0);
        check("rst_rdata", readdata, 0);
        check("rst_irq", irq, 0);
        exp_bits.delete();
        phy_oe = 1'b0;
        break;
      end
      if (lock_rise != 0) begin
        if (inj == 0 && rise_n == lock_rise) begin
          chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h5555_0433; inj = 1;
        end else if (inj == 1) begin
          address = 2'd3; writedata = 32'h8000_0005; inj = 2;
        end else if (inj == 2) begin
          chipselect = 1'b0; write_n = 1'b1; address = 2'd1; inj = 3;
        end
      end
      if (w1c_cyc != 0) begin
        if (cyc == w1c_cyc) begin
          chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h2;
        end else if (cyc == w1c_cyc + 1) begin
          chipselect = 1'b0; write_n = 1'b1;
        end
      end
      addr_q = address;
    end
    if (abort_rise == 0) begin
      check("frame_done", finished, 1);
      check("frame_len", cyc, 128 * (div + 1) + 1);
      check("status_end", readdata[2:0], {(is_rd && !present), 2'b10});
      check("mdc_idle", mdc, 0);
      check("oe_idle", dut.mdio_oe, 0);
      check("bits_left", exp_bits.size(), 0);
      phy_oe = 1'b0;
      if (is_rd) begin
        bus_read(2'd2, d);
        check("rdata", d, {16'h0, exp_rdata.pop_front()});
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 0);
    check("rst_irq0", irq, 0);
    check("rst_mdc0", mdc, 0);
    check("rst_oe0", dut.mdio_oe, 0);
    reset_n = 1'b1;
    bus_read(2'd3, d); check("ctrl_reset", d, 32'd24);
    bus_read(2'd0, d); check("cmd_reset", d, 0);
    bus_read(2'd1, d); check("status_reset", d, 0);
    bus_read(2'd2, d); check("rdata_reset", d, 0);

    // Write frame, div = 1.
    bus_write(2'd3, 32'h0000_0001);
    run_frame(32'hA55A_0024, 1, 1'b0, 16'h0, 0, 0, 0);
    bus_read(2'd2, d); check("rdata_after_wr", d, 0);
    bus_read(2'd0, d); check("cmd_readback", d, 32'hA55A_0024);

    // Read frame with a PHY answering, then with nobody on the bus.
    run_frame(32'h0000_0422, 1, 1'b1, 16'h0141, 0, 0, 0);
    run_frame(32'h0000_0422, 1, 1'b0, 16'h0, 0, 0, 0);

    // Interrupt and W1C clear.
    bus_write(2'd3, 32'h8000_0001);
    check("irq_set", irq, 1);
    bus_write(2'd1, 32'h0000_0006);
    check("irq_clear", irq, 0);
    bus_read(2'd1, d); check("status_clear", d, 0);

    // W1C in the same clock as done is set.
    run_frame(32'h1234_03E5, 1, 1'b0, 16'h0, 0, 255, 0);
    check("irq_after_race", irq, 1);

    // Busy lockout of CMD and div writes.
    run_frame(32'hC3C3_0011, 1, 1'b0, 16'h0, 40, 0, 0);
    bus_read(2'd0, d); check("lock_cmd", d, 32'hC3C3_0011);
    bus_read(2'd3, d); check("lock_ctrl", d, 32'h8000_0001);

    // Reset during the header, then a full frame.
    run_frame(32'h0F0F_0021, 1, 1'b0, 16'h0, 0, 0, 40);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, d); check("abort_status", d, 0);
    bus_read(2'd3, d); check("abort_ctrl", d, 32'd24);
    bus_read(2'd0, d); check("abort_cmd", d, 0);
    bus_write(2'd3, 32'h0000_0001);
    run_frame(32'h0000_0467, 1, 1'b1, 16'hBEEF, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
